psum_accum_array: RTL and testbench

- Parametrised successor to the fixed 4-lane accumulate/bias/output path behind the conv_4U engines.
- Takes N_LANE convolution results per cycle and accumulates partial sums across input channels in an external partial-sum SRAM.
- Adds a per-lane bias on the first input channel.
- On the last input channel, applies optional ReLU, an arithmetic right shift and saturation, then packs the lanes into one output-SRAM write.
- Sits between the conv lanes and the Mout SRAM; the controller drives first/last/pixel index.

---
 rtl/psum_accum_array_if.sv | 46 ++++
 rtl/psum_accum_array.sv | 246 ++++++++++++++++++++++++
 tb/tb_psum_accum_array.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/psum_accum_array_if.sv
// Bus bundle for psum_accum_array: controller/result inputs, bias loading,
// partial-sum SRAM port, output SRAM write port and status.
interface psum_accum_array_if #(
    parameter int N_LANE = 4,
    parameter int DW     = 32,
    parameter int OW     = 8,
    parameter int AW     = 32
);
    logic                     clr;
    logic                     bias_push;
    logic [DW-1:0]            bias_in;
    logic                     bias_ready;
    logic                     res_valid;
    logic [N_LANE*DW-1:0]     res_data;
    logic [AW-1:0]            pix_idx;
    logic                     first;
    logic                     last;
    logic                     relu_en;
    logic [4:0]               shift_amt;
    logic                     out_signed;
    logic [AW-1:0]            ps_addr;
    logic [N_LANE*DW-1:0]     ps_R_data;
    logic [N_LANE*DW/8-1:0]   ps_W_req;
    logic [N_LANE*DW-1:0]     ps_W_data;
    logic [N_LANE*OW/8-1:0]   out_W_req;
    logic [AW-1:0]            out_addr;
    logic [N_LANE*OW-1:0]     out_data;
    logic                     busy;
    logic [15:0]              sat_cnt;

    // Controller / memory side
    modport master (
        output clr, bias_push, bias_in, res_valid, res_data, pix_idx, first, last,
               relu_en, shift_amt, out_signed, ps_R_data,
        input  bias_ready, ps_addr, ps_W_req, ps_W_data, out_W_req, out_addr,
               out_data, busy, sat_cnt
    );

    // Accumulator side
    modport slave (
        input  clr, bias_push, bias_in, res_valid, res_data, pix_idx, first, last,
               relu_en, shift_amt, out_signed, ps_R_data,
        output bias_ready, ps_addr, ps_W_req, ps_W_data, out_W_req, out_addr,
               out_data, busy, sat_cnt
    );
endinterface

// File: rtl/psum_accum_array.sv
// Partial-sum accumulate / bias / post-process array for N_LANE conv lanes.
// S0 issues the partial-sum read, S1 combines and either writes the psum
// back or post-processes (ReLU, shift, saturate) into a registered output
// write. A same-pixel S1 write is forwarded into the following S1 because
// the write owns the shared SRAM port in that cycle.
module psum_accum_array #(
    parameter int N_LANE = 4,
    parameter int DW     = 32,
    parameter int OW     = 8,
    parameter int AW     = 32
) (
    input  logic              clk,
    input  logic              rst,
    psum_accum_array_if.slave bus
);

    localparam int PSW = N_LANE * DW / 8;
    localparam int OWB = N_LANE * OW / 8;
    localparam int CW  = $clog2(N_LANE + 1);

    localparam logic signed [63:0] SMAX_W = (64'sd1 <<< (OW - 1)) - 64'sd1;
    localparam logic signed [63:0] SMIN_W = -(64'sd1 <<< (OW - 1));
    localparam logic signed [63:0] UMAX_W = (64'sd1 <<< OW) - 64'sd1;
    localparam logic [CW-1:0]      NL_C   = CW'(N_LANE);

    // ReLU, arithmetic shift and clamp of one lane; MSB of result flags a clamp.
    function automatic logic [OW:0] post_proc(
        input logic signed [DW-1:0] sum,
        input logic                 relu,
        input logic [4:0]           sh,
        input logic                 osg
    );
        logic signed [DW-1:0] v;
        logic signed [63:0]   w;
        logic [OW-1:0]        q;
        logic                 sat;
        if (relu && sum[DW-1]) begin
            v = {DW{1'b0}};
        end else begin
            v = sum;
        end
        v = v >>> sh;
        w = 64'(v);
        if (osg) begin
            if (w > SMAX_W) begin
                q = SMAX_W[OW-1:0];
                sat = 1'b1;
            end else if (w < SMIN_W) begin
                q = SMIN_W[OW-1:0];
                sat = 1'b1;
            end else begin
                q = w[OW-1:0];
                sat = 1'b0;
            end
        end else begin
            if (w > UMAX_W) begin
                q = UMAX_W[OW-1:0];
                sat = 1'b1;
            end else if (w < 64'sd0) begin
                q = {OW{1'b0}};
                sat = 1'b1;
            end else begin
                q = w[OW-1:0];
                sat = 1'b0;
            end
        end
        return {sat, q};
    endfunction

    // Bias chain and readiness
    logic signed [DW-1:0]   bias_r [N_LANE];
    logic [CW-1:0]          bias_cnt_r;
    logic                   bias_ready_r;

    // S1 pipeline registers
    logic                   s1_valid_r;
    logic [N_LANE*DW-1:0]   s1_data_r;
    logic [AW-1:0]          s1_pix_r;
    logic                   s1_first_r;
    logic                   s1_last_r;
    logic                   s1_fwd_r;
    logic [N_LANE*DW-1:0]   fwd_data_r;

    // Output stage registers
    logic [OWB-1:0]         out_W_req_r;
    logic [AW-1:0]          out_addr_r;
    logic [N_LANE*OW-1:0]   out_data_r;
    logic [15:0]            sat_cnt_r;

    // Combinational
    logic                   live_s;
    logic                   fwd_s;
    logic [N_LANE*DW-1:0]   sum_s;
    logic [N_LANE*OW-1:0]   pack_s;
    logic [CW-1:0]          sat_inc_s;
    logic [16:0]            sat_sum_s;
    logic [AW-1:0]          ps_addr_s;
    logic [PSW-1:0]         ps_W_req_s;
    logic [N_LANE*DW-1:0]   ps_W_data_s;

    assign live_s    = rst & ~bus.clr;
    assign fwd_s     = bus.res_valid & s1_valid_r & ~s1_last_r & (bus.pix_idx == s1_pix_r);
    assign sat_sum_s = {1'b0, sat_cnt_r} + 17'(sat_inc_s);

    // Per-lane combine of result with bias / forwarded / SRAM psum, then post-process
    always_comb begin
        logic signed [DW-1:0] res_l;
        logic signed [DW-1:0] add_l;
        logic signed [DW-1:0] sum_l;
        logic [OW:0]          pp_l;
        sum_s     = {(N_LANE*DW){1'b0}};
        pack_s    = {(N_LANE*OW){1'b0}};
        sat_inc_s = {CW{1'b0}};
        res_l     = {DW{1'b0}};
        add_l     = {DW{1'b0}};
        sum_l     = {DW{1'b0}};
        pp_l      = {(OW+1){1'b0}};
        for (int l = 0; l < N_LANE; l++) begin
            res_l = s1_data_r[(N_LANE-1-l)*DW +: DW];
            if (s1_first_r) begin
                add_l = bias_r[l];
            end else if (s1_fwd_r) begin
                add_l = fwd_data_r[(N_LANE-1-l)*DW +: DW];
            end else begin
                add_l = bus.ps_R_data[(N_LANE-1-l)*DW +: DW];
            end
            sum_l = res_l + add_l;
            sum_s[(N_LANE-1-l)*DW +: DW] = sum_l;
            pp_l = post_proc(sum_l, bus.relu_en, bus.shift_amt, bus.out_signed);
            pack_s[(N_LANE-1-l)*OW +: OW] = pp_l[OW-1:0];
            sat_inc_s = sat_inc_s + CW'(pp_l[OW]);
        end
    end

    // Shared psum SRAM port: S1 write wins over the S0 read
    always_comb begin
        ps_addr_s   = {AW{1'b0}};
        ps_W_req_s  = {PSW{1'b0}};
        ps_W_data_s = {(N_LANE*DW){1'b0}};
        if (live_s && s1_valid_r && !s1_last_r) begin
            ps_addr_s   = s1_pix_r;
            ps_W_req_s  = {PSW{1'b1}};
            ps_W_data_s = sum_s;
        end else if (live_s && bus.res_valid) begin
            ps_addr_s   = bus.pix_idx;
        end else begin
            ps_addr_s   = {AW{1'b0}};
        end
    end

    // Bias shift chain and saturating push counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int l = 0; l < N_LANE; l++) bias_r[l] <= {DW{1'b0}};
            bias_cnt_r   <= {CW{1'b0}};
            bias_ready_r <= 1'b0;
        end else if (bus.clr) begin
            for (int l = 0; l < N_LANE; l++) bias_r[l] <= {DW{1'b0}};
            bias_cnt_r   <= {CW{1'b0}};
            bias_ready_r <= 1'b0;
        end else if (bus.bias_push) begin
            for (int l = 0; l < N_LANE - 1; l++) bias_r[l] <= bias_r[l+1];
            bias_r[N_LANE-1] <= bus.bias_in;
            if (bias_cnt_r == NL_C) begin
                bias_cnt_r   <= NL_C;
                bias_ready_r <= 1'b1;
            end else begin
                bias_cnt_r   <= bias_cnt_r + CW'(1);
                bias_ready_r <= ((bias_cnt_r + CW'(1)) == NL_C);
            end
        end else begin
            bias_cnt_r   <= bias_cnt_r;
            bias_ready_r <= bias_ready_r;
        end
    end

    // S0 -> S1 capture, including the same-pixel forward of S1 sums
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {(N_LANE*DW){1'b0}};
            s1_pix_r   <= {AW{1'b0}};
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_fwd_r   <= 1'b0;
            fwd_data_r <= {(N_LANE*DW){1'b0}};
        end else if (bus.clr) begin
            s1_valid_r <= 1'b0;
            s1_data_r  <= {(N_LANE*DW){1'b0}};
            s1_pix_r   <= {AW{1'b0}};
            s1_first_r <= 1'b0;
            s1_last_r  <= 1'b0;
            s1_fwd_r   <= 1'b0;
            fwd_data_r <= {(N_LANE*DW){1'b0}};
        end else begin
            s1_valid_r <= bus.res_valid;
            if (bus.res_valid) begin
                s1_data_r  <= bus.res_data;
                s1_pix_r   <= bus.pix_idx;
                s1_first_r <= bus.first;
                s1_last_r  <= bus.last;
                s1_fwd_r   <= fwd_s;
            end else begin
                s1_fwd_r   <= 1'b0;
            end
            if (fwd_s) begin
                fwd_data_r <= sum_s;
            end else begin
                fwd_data_r <= fwd_data_r;
            end
        end
    end

    // Registered output write and sticky saturation counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_W_req_r <= {OWB{1'b0}};
            out_addr_r  <= {AW{1'b0}};
            out_data_r  <= {(N_LANE*OW){1'b0}};
            sat_cnt_r   <= 16'h0000;
        end else if (bus.clr) begin
            out_W_req_r <= {OWB{1'b0}};
            out_addr_r  <= {AW{1'b0}};
            out_data_r  <= {(N_LANE*OW){1'b0}};
            sat_cnt_r   <= 16'h0000;
        end else if (s1_valid_r && s1_last_r) begin
            out_W_req_r <= {OWB{1'b1}};
            out_addr_r  <= s1_pix_r;
            out_data_r  <= pack_s;
            sat_cnt_r   <= sat_sum_s[16] ? 16'hFFFF : sat_sum_s[15:0];
        end else begin
            out_W_req_r <= {OWB{1'b0}};
        end
    end

    assign bus.bias_ready = bias_ready_r;
    assign bus.ps_addr    = ps_addr_s;
    assign bus.ps_W_req   = ps_W_req_s;
    assign bus.ps_W_data  = ps_W_data_s;
    assign bus.out_W_req  = out_W_req_r;
    assign bus.out_addr   = out_addr_r;
    assign bus.out_data   = out_data_r;
    assign bus.busy       = s1_valid_r;
    assign bus.sat_cnt    = sat_cnt_r;

endmodule

// File: tb/tb_psum_accum_array.sv
// Directed, table-driven bench for psum_accum_array with a 1-cycle-latency
// partial-sum SRAM model whose unwritten words read back as junk.
module tb_psum_accum_array;

    localparam int N_LANE = 4;
    localparam int DW     = 32;
    localparam int OW     = 8;
    localparam int AW     = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    psum_accum_array_if #(.N_LANE(N_LANE), .DW(DW), .OW(OW), .AW(AW)) bus_if ();

    psum_accum_array #(.N_LANE(N_LANE), .DW(DW), .OW(OW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int checks = 0;
    int errors = 0;

    // Partial-sum SRAM model
    logic [127:0] mem [16];
    logic [15:0]  mem_vld = 16'h0000;
    always @(posedge clk) begin
        if (bus_if.ps_W_req == 16'hFFFF) begin
            mem[bus_if.ps_addr[3:0]]     <= bus_if.ps_W_data;
            mem_vld[bus_if.ps_addr[3:0]] <= 1'b1;
        end
        if (mem_vld[bus_if.ps_addr[3:0]])
            bus_if.ps_R_data <= mem[bus_if.ps_addr[3:0]];
        else
            bus_if.ps_R_data <= {4{32'hBAD0_0BAD}};
    end

    typedef struct {
        logic [127:0] res;
        logic         relu;
        logic [4:0]   sh;
        logic         osg;
        logic [31:0]  exp_out;
        logic [15:0]  exp_sat;
    } vec_t;

    function automatic logic [127:0] pk(input int a, input int b, input int c, input int d);
        return {a, b, c, d};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [127:0] res, input logic [31:0] pix, input logic f,
                         input logic l, input logic rl, input logic [4:0] sh, input logic os);
        bus_if.res_valid  = 1'b1;
        bus_if.res_data   = res;
        bus_if.pix_idx    = pix;
        bus_if.first      = f;
        bus_if.last       = l;
        bus_if.relu_en    = rl;
        bus_if.shift_amt  = sh;
        bus_if.out_signed = os;
    endtask

    task automatic idle;
        bus_if.res_valid = 1'b0;
        bus_if.first     = 1'b0;
        bus_if.last      = 1'b0;
    endtask

    vec_t vecs [5];
    logic seen_wr;

    initial begin
        // bias is zero while these run; sat_exp is cumulative
        vecs[0] = '{pk(1000, -300, 5, -5),      1'b0, 5'd0,  1'b1, 32'h7F8005FB, 16'd2};
        vecs[1] = '{pk(-5, 1000, -300, 77),     1'b1, 5'd0,  1'b1, 32'h007F004D, 16'd3};
        vecs[2] = '{pk(-5, 300, 255, 256),      1'b0, 5'd0,  1'b0, 32'h00FFFFFF, 16'd6};
        vecs[3] = '{pk(-1, -16, 1000, -2048),   1'b0, 5'd4,  1'b1, 32'hFFFF3E80, 16'd6};
        vecs[4] = '{pk(-1, 32'h7FFFFFFF, 32'h80000000, 5), 1'b0, 5'd31, 1'b1, 32'hFF00FF00, 16'd6};

        bus_if.clr        = 1'b0;
        bus_if.bias_push  = 1'b0;
        bus_if.bias_in    = 32'd0;
        bus_if.res_data   = 128'd0;
        bus_if.pix_idx    = 32'd0;
        bus_if.relu_en    = 1'b0;
        bus_if.shift_amt  = 5'd0;
        bus_if.out_signed = 1'b0;
        idle();
        #1;
        chk("rst_busy",      32'(bus_if.busy), 32'd0);
        chk("rst_bias_rdy",  32'(bus_if.bias_ready), 32'd0);
        chk("rst_out_req",   32'(bus_if.out_W_req), 32'd0);
        chk("rst_ps_req",    32'(bus_if.ps_W_req), 32'd0);
        chk("rst_sat",       32'(bus_if.sat_cnt), 32'd0);
        chk("rst_out_data",  bus_if.out_data, 32'd0);
        tick();
        tick();
        rst = 1'b1;

        // Bias chain load: 10, 20, 30, 40
        for (int i = 0; i < 4; i++) begin
            bus_if.bias_push = 1'b1;
            bus_if.bias_in   = 32'(10 * (i + 1));
            tick();
            if (i == 2) chk("bias_rdy_after3", 32'(bus_if.bias_ready), 32'd0);
        end
        bus_if.bias_push = 1'b0;
        chk("bias_rdy_after4", 32'(bus_if.bias_ready), 32'd1);

        // Single first+last result, res 5 on all lanes
        drive(pk(5, 5, 5, 5), 32'd1, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
        tick();
        idle();
        chk("t1_busy",      32'(bus_if.busy), 32'd1);
        chk("t1_no_ps_wr",  32'(bus_if.ps_W_req), 32'd0);
        chk("t1_out_early", 32'(bus_if.out_W_req), 32'd0);
        tick();
        chk("t1_out_req",   32'(bus_if.out_W_req), 32'hF);
        chk("t1_out_data",  bus_if.out_data, 32'h0F19232D);
        chk("t1_out_addr",  bus_if.out_addr, 32'd1);
        tick();
        chk("t1_pulse",     32'(bus_if.out_W_req), 32'd0);
        chk("t1_hold",      bus_if.out_data, 32'h0F19232D);

        // Back-to-back same pixel: forwarded sums replace junk SRAM data
        drive(pk(1, 2, 3, 4), 32'd7, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1);
        tick();
        chk("fwd_ps_req",  32'(bus_if.ps_W_req), 32'hFFFF);
        chk("fwd_ps_addr", bus_if.ps_addr, 32'd7);
        chk("fwd_ps_data", bus_if.ps_W_data, pk(11, 22, 33, 44));
        drive(pk(100, -100, 3, -50), 32'd7, 1'b0, 1'b1, 1'b0, 5'd0, 1'b1);
        tick();
        idle();
        chk("fwd_no_wr",   32'(bus_if.ps_W_req), 32'd0);
        tick();
        chk("fwd_out_req", 32'(bus_if.out_W_req), 32'hF);
        chk("fwd_out",     bus_if.out_data, 32'h6FB224FA);

        // clr kills an in-flight last result and clears bias state
        drive(pk(5, 5, 5, 5), 32'd2, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
        tick();
        idle();
        chk("clr_busy_before", 32'(bus_if.busy), 32'd1);
        bus_if.clr = 1'b1;
        tick();
        bus_if.clr = 1'b0;
        chk("clr_out_req",  32'(bus_if.out_W_req), 32'd0);
        chk("clr_busy",     32'(bus_if.busy), 32'd0);
        chk("clr_bias_rdy", 32'(bus_if.bias_ready), 32'd0);
        chk("clr_out_data", bus_if.out_data, 32'd0);
        tick();
        chk("clr_no_late_wr", 32'(bus_if.out_W_req), 32'd0);

        // Zero biases
        for (int i = 0; i < 4; i++) begin
            bus_if.bias_push = 1'b1;
            bus_if.bias_in   = 32'd0;
            tick();
        end
        bus_if.bias_push = 1'b0;

        // Post-processing table
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].res, 32'(i + 8), 1'b1, 1'b1, vecs[i].relu, vecs[i].sh, vecs[i].osg);
            tick();
            idle();
            tick();
            chk($sformatf("vec%0d_req", i),  32'(bus_if.out_W_req), 32'hF);
            chk($sformatf("vec%0d_out", i),  bus_if.out_data, vecs[i].exp_out);
            chk($sformatf("vec%0d_sat", i),  32'(bus_if.sat_cnt), 32'(vecs[i].exp_sat));
        end

        // Three channels on one pixel through the SRAM, unsigned shift 2
        drive(pk(100, 100, 100, 100), 32'd3, 1'b1, 1'b0, 1'b0, 5'd2, 1'b0);
        tick();
        idle();
        chk("ch1_ps_req",  32'(bus_if.ps_W_req), 32'hFFFF);
        chk("ch1_ps_data", bus_if.ps_W_data, pk(100, 100, 100, 100));
        tick();
        tick();
        drive(pk(100, 100, 100, 100), 32'd3, 1'b0, 1'b0, 1'b0, 5'd2, 1'b0);
        tick();
        idle();
        chk("ch2_ps_req",  32'(bus_if.ps_W_req), 32'hFFFF);
        chk("ch2_ps_data", bus_if.ps_W_data, pk(200, 200, 200, 200));
        tick();
        tick();
        drive(pk(100, 100, 100, 100), 32'd3, 1'b0, 1'b1, 1'b0, 5'd2, 1'b0);
        tick();
        idle();
        chk("ch3_no_ps_wr", 32'(bus_if.ps_W_req), 32'd0);
        tick();
        chk("ch3_out",      bus_if.out_data, 32'h4B4B4B4B);
        chk("ch3_addr",     bus_if.out_addr, 32'd3);
        chk("ch3_sat",      32'(bus_if.sat_cnt), 32'd6);

        // Stream clamping results until sat_cnt pins at 0xFFFF
        drive(pk(1000, 1000, 1000, 1000), 32'd5, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
        repeat (16384) tick();
        idle();
        tick();
        tick();
        chk("sat_pinned", 32'(bus_if.sat_cnt), 32'hFFFF);
        chk("sat_out",    bus_if.out_data, 32'h7F7F7F7F);

        // Asynchronous reset mid-pipeline
        drive(pk(1000, -300, 5, -5), 32'd4, 1'b1, 1'b1, 1'b0, 5'd0, 1'b1);
        tick();
        idle();
        chk("arst_busy_before", 32'(bus_if.busy), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_busy",     32'(bus_if.busy), 32'd0);
        chk("arst_out_data", bus_if.out_data, 32'd0);
        chk("arst_out_addr", bus_if.out_addr, 32'd0);
        chk("arst_sat",      32'(bus_if.sat_cnt), 32'd0);
        chk("arst_bias_rdy", 32'(bus_if.bias_ready), 32'd0);
        chk("arst_ps_req",   32'(bus_if.ps_W_req), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        seen_wr = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus_if.out_W_req != 4'h0) seen_wr = 1'b1;
        end
        chk("arst_no_wr",     32'(seen_wr), 32'd0);
        chk("arst_bias_rdy2", 32'(bus_if.bias_ready), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
